oclkgen: RTL and testbench
==========================

# oclkgen

Parametrised DDR clock-burst generator for iCE40 output pins, driving NCHAN pins (flash/SPI SCK, external bus clocks) from a single system clock. Produces a programmed number of output clock cycles at full DDR rate (one output cycle per i_clk) or at an integer division of i_clk. Each burst is started by a strobe and ends with a done pulse. Each pin's SB_IO output register is fed a 2-bit DDR pair per i_clk. The block sits between bus-master state machines and the package pins, replacing bare per-pin DDR output wrappers.

## Interface
- NCHAN, 1: number of output clock pins.
- LGDIV, 4: width of the divider field.
- LGCOUNT, 8: width of the burst-length field; maximum burst is 2^LGCOUNT-1 cycles.

- i_clk  in  1  system clock. All logic is on its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_stb  in  1  start request. Sampled only while o_busy=0.
- i_div  in  LGDIV  0 = full rate. k>0 = output half-period of k i_clk cycles.
- i_count  in  LGCOUNT  number of output clock cycles in the burst.
- i_cpol  in  1  idle level of the output clock.
- i_en  in  NCHAN  per-channel enable mask, latched at start.
- o_busy  out  1  burst in progress.
- o_done  out  1  one-cycle pulse at burst end.
- o_ddr  out  2*NCHAN  registered DDR pairs. Pair k is o_ddr[2k+1:2k]. Bit 2k+1 is the first half of i_clk (rising edge); bit 2k is the second half.
- o_pin  out  NCHAN  package pins.

## Operation
- FSM states: IDLE and RUN.
- IDLE:
  - When i_stb=1 and i_count!=0, latch i_div, i_count, i_cpol and i_en, then go to RUN.
  - When i_stb=1 and i_count=0, latch i_cpol, pulse o_done and stay in IDLE. No toggling occurs.
- RUN, general rules:
  - i_stb is ignored.
  - When the cycle counter reaches the latched count, return to IDLE.
- Output levels:
  - Idle level is the latched cpol; both bits of every pair equal cpol.
  - Each output cycle is a first half at ~cpol followed by a second half at cpol.
- Full rate (div=0):
  - Every enabled pair equals {~cpol, cpol} on each RUN cycle.
  - One output cycle per i_clk.
- Divided (div=k):
  - Both bits of the pair equal ~cpol for k cycles, then cpol for k cycles.
  - Uses a half-period counter (LGDIV bits) and a phase bit.
  - The cycle counter increments at the end of each second half.
- Disabled channels (latched i_en bit = 0) hold the idle level throughout the burst.
- All outputs are registered. Nothing combinational runs from inputs to outputs.

## Timing
- Reset values: o_busy=0, o_done=0, o_ddr=all zeros, latched cpol=0, FSM=IDLE, all counters=0.
- Start timing, for i_stb accepted at edge T:
  - At T+1: o_busy=1 and the first active pair appears on o_ddr.
- Burst length:
  - div=0: the last active pair is at T+N.
  - div=k: the last active pair is at T+2kN.
- Burst end, on the cycle after the last active pair:
  - o_done=1.
  - o_busy=0.
  - o_ddr is at idle.
  - A new i_stb is accepted that same cycle.
- count=0: o_done=1 at T+1 with o_busy held 0.
- o_busy and o_done are never both high.
- Pin timing: the SB_IO output register adds one i_clk of latency from o_ddr to o_pin.
- Reset asserted mid-burst: all outputs immediately take their reset values. The FSM goes to IDLE with no o_done pulse.
- Input changes during RUN have no effect until the next accepted start.

## Configuration
- OCLKGEN_SBIO_EN defined:
  - One SB_IO per channel, with PIN_TYPE 6'b0100_01 (registered DDR output).
  - OUTPUT_CLK=i_clk, CLOCK_ENABLE=1, OUTPUT_ENABLE=1.
  - D_OUT_0=o_ddr[2k+1], D_OUT_1=o_ddr[2k].
- OCLKGEN_SBIO_EN not defined:
  - Behavioural model for simulation and formal.
  - o_ddr is re-registered on i_clk into q.
  - o_pin[k] = i_clk ? q[2k+1] : q[2k].
  - Latency is identical to the SB_IO build.

## Test plan
- Reset: hold i_reset_n=0 and toggle the clock -> o_busy=0, o_done=0, o_ddr=0, o_pin=0.
- Full rate: NCHAN=2, div=0, count=3, cpol=0, en=2'b11 -> o_ddr=4'b1010 for 3 cycles, then o_done pulse with o_ddr=0.
- Divided: div=2, count=2, cpol=1 -> pair sequence 00,00,11,11,00,00,11,11 -> then o_done with pair at 11.
- Mask: NCHAN=2, en=2'b01, div=0, count=4 -> channel 0 toggles while o_ddr[3:2] holds {cpol,cpol}. Also, i_stb pulses mid-burst are ignored and the burst length stays 4.
- count=0 strobe -> o_done at T+1, o_busy stays 0, no pair change other than cpol.
- Reset mid-burst at RUN cycle 2 of count=5 -> outputs reset immediately, no o_done. The next start after release runs a full 5-cycle burst.

Source files
------------

// File: rtl/oclkgen_if.sv
// Burst-control interface for oclkgen: start/config from the bus master, status and DDR/pin outputs back.
interface oclkgen_if #(
    parameter int NCHAN   = 1,
    parameter int LGDIV   = 4,
    parameter int LGCOUNT = 8
);
    logic                 i_stb;
    logic [LGDIV-1:0]     i_div;
    logic [LGCOUNT-1:0]   i_count;
    logic                 i_cpol;
    logic [NCHAN-1:0]     i_en;
    logic                 o_busy;
    logic                 o_done;
    logic [2*NCHAN-1:0]   o_ddr;
    logic [NCHAN-1:0]     o_pin;

    modport master (output i_stb, i_div, i_count, i_cpol, i_en,
                    input  o_busy, o_done, o_ddr, o_pin);
    modport slave  (input  i_stb, i_div, i_count, i_cpol, i_en,
                    output o_busy, o_done, o_ddr, o_pin);
endinterface

// File: rtl/oclkgen.sv
// DDR clock-burst generator for iCE40 pins. Define OCLKGEN_SBIO_EN to drive pins through SB_IO
// primitives; otherwise a behavioural DDR output register model is used.
module oclkgen_lane (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       drive,
    input  logic       en,
    input  logic       cpol,
    input  logic       act_hi,
    input  logic       act_lo,
    output logic [1:0] ddr,
    output logic       pin
);
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            ddr <= 2'b00;
        else if (drive && en)
            ddr <= {act_hi, act_lo};
        else
            ddr <= {cpol, cpol};
    end

`ifdef OCLKGEN_SBIO_EN
    SB_IO #(
        .PIN_TYPE(6'b0100_01)
    ) u_io (
        .PACKAGE_PIN   (pin),
        .OUTPUT_CLK    (i_clk),
        .CLOCK_ENABLE  (1'b1),
        .OUTPUT_ENABLE (1'b1),
        .D_OUT_0       (ddr[1]),
        .D_OUT_1       (ddr[0])
    );
`else
    logic [1:0] q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            q <= 2'b00;
        else
            q <= ddr;
    end

    // First half of i_clk shows the rising-edge bit, second half the falling-edge bit.
    assign pin = i_clk ? q[1] : q[0];
`endif
endmodule

module oclkgen #(
    parameter int NCHAN   = 1,
    parameter int LGDIV   = 4,
    parameter int LGCOUNT = 8
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    oclkgen_if.slave   bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [LGCOUNT-1:0] CNT_ONE = LGCOUNT'(1);
    localparam logic [LGDIV-1:0]   HP_ONE  = LGDIV'(1);

    state_t               state, state_nxt;
    logic                 cpol_q, cpol_nxt;
    logic [LGDIV-1:0]     div_q, div_nxt;
    logic [LGCOUNT-1:0]   count_q, count_nxt;
    logic [NCHAN-1:0]     en_q, en_nxt;
    logic [LGCOUNT-1:0]   cyc_cnt, cyc_nxt;
    logic [LGDIV-1:0]     hp_cnt, hp_nxt;
    logic                 phase, phase_nxt;
    logic                 busy, busy_nxt;
    logic                 done, done_nxt;
    logic                 drive_nxt, half_end;
    logic                 act_hi, act_lo;
    logic [NCHAN-1:0][1:0] ddr;
    logic [NCHAN-1:0]     pin;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cpol_q  <= 1'b0;
            div_q   <= '0;
            count_q <= '0;
            en_q    <= '0;
            cyc_cnt <= '0;
            hp_cnt  <= '0;
            phase   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            cpol_q  <= cpol_nxt;
            div_q   <= div_nxt;
            count_q <= count_nxt;
            en_q    <= en_nxt;
            cyc_cnt <= cyc_nxt;
            hp_cnt  <= hp_nxt;
            phase   <= phase_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // hp_cnt holds how many i_clk of the current half have already been emitted.
    assign half_end = (div_q == '0) || (phase && (hp_cnt == div_q));

    always_comb begin
        state_nxt = state;
        cpol_nxt  = cpol_q;
        div_nxt   = div_q;
        count_nxt = count_q;
        en_nxt    = en_q;
        cyc_nxt   = cyc_cnt;
        hp_nxt    = hp_cnt;
        phase_nxt = phase;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        drive_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_stb) begin
                    cpol_nxt = bus.i_cpol;
                    if (bus.i_count == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = RUN;
                        busy_nxt  = 1'b1;
                        div_nxt   = bus.i_div;
                        count_nxt = bus.i_count;
                        en_nxt    = bus.i_en;
                        cyc_nxt   = '0;
                        hp_nxt    = HP_ONE;
                        phase_nxt = 1'b0;
                        drive_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (half_end && (cyc_cnt + CNT_ONE == count_q)) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    cyc_nxt   = '0;
                    hp_nxt    = '0;
                    phase_nxt = 1'b0;
                end else begin
                    drive_nxt = 1'b1;
                    if (div_q == '0) begin
                        cyc_nxt = cyc_cnt + CNT_ONE;
                    end else if (hp_cnt == div_q) begin
                        hp_nxt    = HP_ONE;
                        phase_nxt = ~phase;
                        if (phase)
                            cyc_nxt = cyc_cnt + CNT_ONE;
                    end else begin
                        hp_nxt = hp_cnt + HP_ONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Full rate: {~cpol,cpol}; divided: both bits at the level of the upcoming half.
        act_hi = (div_nxt != '0 && phase_nxt) ? cpol_nxt : ~cpol_nxt;
        act_lo = (div_nxt == '0 || phase_nxt) ? cpol_nxt : ~cpol_nxt;
    end

    for (genvar k = 0; k < NCHAN; k++) begin : g_lane
        oclkgen_lane u_lane (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .drive     (drive_nxt),
            .en        (en_nxt[k]),
            .cpol      (cpol_nxt),
            .act_hi    (act_hi),
            .act_lo    (act_lo),
            .ddr       (ddr[k]),
            .pin       (pin[k])
        );
    end

    assign bus.o_busy = busy;
    assign bus.o_done = done;
    assign bus.o_ddr  = ddr;
    assign bus.o_pin  = pin;
endmodule

// File: tb/tb_oclkgen.sv
// Randomized self-checking bench for oclkgen: burst sequences are built per output cycle from
// div/count/cpol/en and compared cycle by cycle, including the one-cycle pin latency.
module tb_oclkgen;
    localparam int NCHAN   = 2;
    localparam int LGDIV   = 4;
    localparam int LGCOUNT = 8;
    localparam int W       = 2 * NCHAN;

    typedef logic [W-1:0] word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    word_t prev_exp = '0;
    logic mcpol = 1'b0;

    always #5 clk = ~clk;

    oclkgen_if #(.NCHAN(NCHAN), .LGDIV(LGDIV), .LGCOUNT(LGCOUNT)) bus ();

    oclkgen #(.NCHAN(NCHAN), .LGDIV(LGDIV), .LGCOUNT(LGCOUNT)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic word_t pair_word(input logic h, input logic l, input logic c,
                                        input logic [NCHAN-1:0] en);
        word_t w;
        for (int k = 0; k < NCHAN; k++) begin
            w[2*k+1] = en[k] ? h : c;
            w[2*k]   = en[k] ? l : c;
        end
        return w;
    endfunction

    function automatic word_t idle_word(input logic c);
        return pair_word(c, c, c, '0);
    endfunction

    // One clock: outputs checked just after the rising edge, pin low half after the falling edge.
    task automatic tick(input logic eb, input logic ed, input word_t ew);
        @(posedge clk);
        #1;
        chk("busy", 32'(bus.o_busy), 32'(eb));
        chk("done", 32'(bus.o_done), 32'(ed));
        chk("ddr", 32'(bus.o_ddr), 32'(ew));
        for (int k = 0; k < NCHAN; k++)
            chk("pin_hi", 32'(bus.o_pin[k]), 32'(prev_exp[2*k+1]));
        @(negedge clk);
        #1;
        for (int k = 0; k < NCHAN; k++)
            chk("pin_lo", 32'(bus.o_pin[k]), 32'(prev_exp[2*k]));
        prev_exp = ew;
    endtask

    task automatic noise();
        bus.i_stb   = 1'($urandom);
        bus.i_div   = LGDIV'($urandom);
        bus.i_count = LGCOUNT'($urandom);
        bus.i_cpol  = 1'($urandom);
        bus.i_en    = NCHAN'($urandom);
    endtask

    task automatic burst(input int div, input int cnt, input logic c,
                         input logic [NCHAN-1:0] en, input bit noisy);
        word_t q[$];
        bus.i_stb   = 1'b1;
        bus.i_div   = LGDIV'(div);
        bus.i_count = LGCOUNT'(cnt);
        bus.i_cpol  = c;
        bus.i_en    = en;
        mcpol       = c;
        if (cnt == 0) begin
            tick(1'b0, 1'b1, idle_word(c));
            bus.i_stb = 1'b0;
            return;
        end
        for (int n = 0; n < cnt; n++) begin
            if (div == 0) begin
                q.push_back(pair_word(~c, c, c, en));
            end else begin
                for (int j = 0; j < div; j++) q.push_back(pair_word(~c, ~c, c, en));
                for (int j = 0; j < div; j++) q.push_back(pair_word(c, c, c, en));
            end
        end
        foreach (q[i]) begin
            tick(1'b1, 1'b0, q[i]);
            if (noisy) noise();
            else bus.i_stb = 1'b0;
        end
        tick(1'b0, 1'b1, idle_word(c));
        bus.i_stb = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.i_stb   = 1'b0;
        bus.i_div   = '0;
        bus.i_count = '0;
        bus.i_cpol  = 1'b0;
        bus.i_en    = '0;
        repeat (3) tick(1'b0, 1'b0, '0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, '0);

        burst(0, 3, 1'b0, 2'b11, 0);
        tick(1'b0, 1'b0, idle_word(mcpol));
        burst(2, 2, 1'b1, 2'b11, 0);
        tick(1'b0, 1'b0, idle_word(mcpol));
        burst(0, 4, 1'b0, 2'b01, 1);
        tick(1'b0, 1'b0, idle_word(mcpol));
        burst(0, 0, 1'b1, 2'b11, 0);
        tick(1'b0, 1'b0, idle_word(mcpol));

        // Reset during RUN cycle 2 of a 5-cycle burst.
        bus.i_stb = 1'b1; bus.i_div = '0; bus.i_count = LGCOUNT'(5);
        bus.i_cpol = 1'b1; bus.i_en = 2'b11;
        tick(1'b1, 1'b0, pair_word(1'b0, 1'b1, 1'b1, 2'b11));
        bus.i_stb = 1'b0;
        tick(1'b1, 1'b0, pair_word(1'b0, 1'b1, 1'b1, 2'b11));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_ddr", 32'(bus.o_ddr), 32'd0);
        chk("rst_pin", 32'(bus.o_pin), 32'd0);
        mcpol = 1'b0;
        prev_exp = '0;
        repeat (2) tick(1'b0, 1'b0, '0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, '0);
        burst(0, 5, 1'b1, 2'b11, 0);
        tick(1'b0, 1'b0, idle_word(mcpol));

        burst(0, 255, 1'b0, 2'b10, 0);
        burst(15, 2, 1'b1, 2'b11, 0);
        burst(1, 2, 1'b0, 2'b11, 0);
        burst(0, 1, 1'b1, 2'b11, 0);
        tick(1'b0, 1'b0, idle_word(mcpol));

        repeat (40) begin
            burst($urandom_range(0, 3), $urandom_range(0, 6), 1'($urandom),
                  NCHAN'($urandom), bit'($urandom));
            repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, idle_word(mcpol));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
